// File: rtl/round_judge_pkg.sv
// Shared encodings for the round judge: player moves, per-round results and FSM states.
package round_judge_pkg;

  typedef enum logic [1:0] {
    MV_NONE     = 2'b00,
    MV_ROCK     = 2'b01,
    MV_PAPER    = 2'b10,
    MV_SCISSORS = 2'b11
  } move_e;

  typedef enum logic [1:0] {
    RES_NONE = 2'b00,
    RES_P1   = 2'b01,
    RES_P2   = 2'b10,
    RES_TIE  = 2'b11
  } res_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_WAIT  = 2'b01,
    ST_JUDGE = 2'b10,
    ST_DONE  = 2'b11
  } state_e;

endpackage

// File: rtl/round_judge_if.sv
// Player handshake and result bus of the round judge; master = players/consumer, slave = judge.
interface round_judge_if #(
  parameter int ROUNDS = 5
);
  localparam int IDX_W = $clog2(ROUNDS + 1);

  logic                  p1_valid;
  logic [1:0]            p1_move;
  logic                  p1_ready;
  logic                  p2_valid;
  logic [1:0]            p2_move;
  logic                  p2_ready;
  logic [2*ROUNDS-1:0]   out_cr;
  logic [IDX_W-1:0]      round_idx;
  logic                  match_done;

  modport master (
    output p1_valid, p1_move, p2_valid, p2_move,
    input  p1_ready, p2_ready, out_cr, round_idx, match_done
  );

  modport slave (
    input  p1_valid, p1_move, p2_valid, p2_move,
    output p1_ready, p2_ready, out_cr, round_idx, match_done
  );
endinterface

// File: rtl/round_judge_rps_compare.sv
// Combinational rock/paper/scissors comparison of two latched moves.
module rps_compare
  import round_judge_pkg::*;
(
  input  move_e p1_move,
  input  move_e p2_move,
  output res_e  result
);

  always_comb begin
    result = RES_P2;
    if (p1_move == MV_NONE || p2_move == MV_NONE) begin
      result = RES_NONE;
    end else if (p1_move == p2_move) begin
      result = RES_TIE;
    end else if ((p1_move == MV_ROCK     && p2_move == MV_SCISSORS) ||
                 (p1_move == MV_SCISSORS && p2_move == MV_PAPER)    ||
                 (p1_move == MV_PAPER    && p2_move == MV_ROCK)) begin
      result = RES_P1;
    end
  end

endmodule

// File: rtl/round_judge.sv
// Round judge: collects one move per player per round, judges it and packs results into out_cr.
// Optional ROUND_TIMEOUT_EN: a lone latched player wins the round after TIMEOUT waiting cycles.
module round_judge
  import round_judge_pkg::*;
#(
  parameter int ROUNDS  = 5,
  parameter int TIMEOUT = 255
) (
  input  logic          newClk,
  input  logic          rst_n,
  input  logic          start,
  round_judge_if.slave  bus
);

  localparam int IDX_W = $clog2(ROUNDS + 1);
  localparam int OUT_W = 2 * ROUNDS;

  if (ROUNDS < 1 || TIMEOUT < 1) begin : g_param_check
    $error("round_judge: ROUNDS and TIMEOUT must both be at least 1");
  end

  state_e             state_q, state_d;
  move_e              p1_move_q, p1_move_d, p2_move_q, p2_move_d;
  logic               p1_lat_q, p1_lat_d, p2_lat_q, p2_lat_d;
  logic               p1_ready_q, p1_ready_d, p2_ready_q, p2_ready_d;
  logic               done_q, done_d;
  logic [OUT_W-1:0]   out_cr_q, out_cr_d;
  logic [IDX_W-1:0]   round_idx_q, round_idx_d;

  logic               p1_acc, p2_acc;
  res_e               cmp_res, judge_res;
  logic [ROUNDS-1:0]  slot_hit;

`ifdef ROUND_TIMEOUT_EN
  localparam int CNT_W = ($clog2(TIMEOUT + 1) > 8) ? $clog2(TIMEOUT + 1) : 8;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
`endif

  rps_compare u_cmp (
    .p1_move (p1_move_q),
    .p2_move (p2_move_q),
    .result  (cmp_res)
  );

  // Ready is registered, so acceptance only depends on flops and the offered move.
  assign p1_acc = bus.p1_valid && p1_ready_q && (bus.p1_move != MV_NONE);
  assign p2_acc = bus.p2_valid && p2_ready_q && (bus.p2_move != MV_NONE);

  always_comb begin
`ifdef ROUND_TIMEOUT_EN
    // Only one latch set while judging means the round timed out.
    if (p1_lat_q && p2_lat_q) begin
      judge_res = cmp_res;
    end else if (p1_lat_q) begin
      judge_res = RES_P1;
    end else begin
      judge_res = RES_P2;
    end
`else
    judge_res = cmp_res;
`endif
  end

  for (genvar gi = 0; gi < ROUNDS; gi++) begin : g_slot
    assign slot_hit[gi] = (state_q == ST_JUDGE) && (round_idx_q == IDX_W'(gi));
  end

  always_comb begin
    state_d     = state_q;
    p1_move_d   = p1_move_q;
    p2_move_d   = p2_move_q;
    p1_lat_d    = p1_lat_q;
    p2_lat_d    = p2_lat_q;
    out_cr_d    = out_cr_q;
    round_idx_d = round_idx_q;
`ifdef ROUND_TIMEOUT_EN
    cnt_d       = cnt_q;
`endif

    case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (p1_acc) begin
          p1_move_d = move_e'(bus.p1_move);
          p1_lat_d  = 1'b1;
        end
        if (p2_acc) begin
          p2_move_d = move_e'(bus.p2_move);
          p2_lat_d  = 1'b1;
        end
        if (p1_lat_d && p2_lat_d) begin
          state_d = ST_JUDGE;
        end
`ifdef ROUND_TIMEOUT_EN
        else if (p1_lat_d ^ p2_lat_d) begin
          if (!(p1_lat_q ^ p2_lat_q)) begin
            cnt_d = '0;
          end else if (cnt_q >= CNT_W'(TIMEOUT)) begin
            state_d = ST_JUDGE;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
`endif
      end
      ST_JUDGE: begin
        for (int k = 0; k < ROUNDS; k++) begin
          if (slot_hit[k]) out_cr_d[2*k +: 2] = judge_res;
        end
        round_idx_d = round_idx_q + 1'b1;
        p1_lat_d    = 1'b0;
        p2_lat_d    = 1'b0;
        p1_move_d   = MV_NONE;
        p2_move_d   = MV_NONE;
`ifdef ROUND_TIMEOUT_EN
        cnt_d       = '0;
`endif
        state_d     = (int'(round_idx_q) + 1 < ROUNDS) ? ST_WAIT : ST_DONE;
      end
      ST_DONE: begin
        if (start) state_d = ST_WAIT;
      end
    endcase

    // start overrides whatever the current state decided.
    if (start) begin
      state_d     = ST_WAIT;
      out_cr_d    = '0;
      round_idx_d = '0;
      p1_lat_d    = 1'b0;
      p2_lat_d    = 1'b0;
      p1_move_d   = MV_NONE;
      p2_move_d   = MV_NONE;
`ifdef ROUND_TIMEOUT_EN
      cnt_d       = '0;
`endif
    end

    p1_ready_d = (state_d == ST_WAIT) && !p1_lat_d;
    p2_ready_d = (state_d == ST_WAIT) && !p2_lat_d;
    done_d     = (state_d == ST_DONE);
  end

  always_ff @(posedge newClk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      p1_move_q   <= MV_NONE;
      p2_move_q   <= MV_NONE;
      p1_lat_q    <= 1'b0;
      p2_lat_q    <= 1'b0;
      p1_ready_q  <= 1'b0;
      p2_ready_q  <= 1'b0;
      done_q      <= 1'b0;
      out_cr_q    <= '0;
      round_idx_q <= '0;
`ifdef ROUND_TIMEOUT_EN
      cnt_q       <= '0;
`endif
    end else begin
      state_q     <= state_d;
      p1_move_q   <= p1_move_d;
      p2_move_q   <= p2_move_d;
      p1_lat_q    <= p1_lat_d;
      p2_lat_q    <= p2_lat_d;
      p1_ready_q  <= p1_ready_d;
      p2_ready_q  <= p2_ready_d;
      done_q      <= done_d;
      out_cr_q    <= out_cr_d;
      round_idx_q <= round_idx_d;
`ifdef ROUND_TIMEOUT_EN
      cnt_q       <= cnt_d;
`endif
    end
  end

  assign bus.p1_ready   = p1_ready_q;
  assign bus.p2_ready   = p2_ready_q;
  assign bus.out_cr     = out_cr_q;
  assign bus.round_idx  = round_idx_q;
  assign bus.match_done = done_q;

endmodule

// File: tb/tb_round_judge.sv
// Directed bench for round_judge: reset, full match, invalid moves, restart, same-edge judge, timeout.
module tb_round_judge;

  localparam logic [1:0] R = 2'b01;
  localparam logic [1:0] P = 2'b10;
  localparam logic [1:0] S = 2'b11;
`ifdef ROUND_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 255;
`endif

  logic clk;
  logic rst_n;
  logic start;
  int   checks;
  int   failures;

  round_judge_if #(.ROUNDS(5)) bus ();

  round_judge #(.ROUNDS(5), .TIMEOUT(TO)) dut (
    .newClk (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus    (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Stimulus helpers; all start and end just after a falling edge.
  task automatic pulse_start();
    start = 1'b1;
    @(posedge clk); @(negedge clk);
    start = 1'b0;
  endtask

  task automatic play_round(input logic [1:0] m1, input logic [1:0] m2);
    bus.p1_valid = 1'b1; bus.p1_move = m1;
    bus.p2_valid = 1'b1; bus.p2_move = m2;
    @(posedge clk); @(negedge clk);
    bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    $display("round p1=%b p2=%b out_cr=%h idx=%0d", m1, m2, bus.out_cr, bus.round_idx);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0;
    bus.p1_valid = 1'b0; bus.p1_move = 2'b00;
    bus.p2_valid = 1'b0; bus.p2_move = 2'b00;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    checks += 5;
    if (bus.out_cr !== 10'h000) begin failures++; $display("FAIL reset_out_cr actual=%h expected=000", bus.out_cr); end
    if (bus.round_idx !== 3'd0) begin failures++; $display("FAIL reset_idx actual=%0d expected=0", bus.round_idx); end
    if (bus.p1_ready !== 1'b0) begin failures++; $display("FAIL reset_p1_ready actual=%b expected=0", bus.p1_ready); end
    if (bus.p2_ready !== 1'b0) begin failures++; $display("FAIL reset_p2_ready actual=%b expected=0", bus.p2_ready); end
    if (bus.match_done !== 1'b0) begin failures++; $display("FAIL reset_done actual=%b expected=0", bus.match_done); end
    $display("test_reset done");
  endtask

  task automatic test_full_match();
    pulse_start();
    checks += 2;
    if (bus.p1_ready !== 1'b1) begin failures++; $display("FAIL start_p1_ready actual=%b expected=1", bus.p1_ready); end
    if (bus.p2_ready !== 1'b1) begin failures++; $display("FAIL start_p2_ready actual=%b expected=1", bus.p2_ready); end
    play_round(R, S);
    checks += 2;
    if (bus.out_cr !== 10'h001) begin failures++; $display("FAIL match_r1_out_cr actual=%h expected=001", bus.out_cr); end
    if (bus.round_idx !== 3'd1) begin failures++; $display("FAIL match_r1_idx actual=%0d expected=1", bus.round_idx); end
    play_round(R, S);
    play_round(R, S);
    play_round(P, P);
    play_round(R, P);
    checks += 5;
    if (bus.out_cr !== 10'h2D5) begin failures++; $display("FAIL match_out_cr actual=%h expected=2d5", bus.out_cr); end
    if (bus.round_idx !== 3'd5) begin failures++; $display("FAIL match_idx actual=%0d expected=5", bus.round_idx); end
    if (bus.match_done !== 1'b1) begin failures++; $display("FAIL match_done actual=%b expected=1", bus.match_done); end
    if (bus.p1_ready !== 1'b0) begin failures++; $display("FAIL match_p1_ready actual=%b expected=0", bus.p1_ready); end
    if (bus.p2_ready !== 1'b0) begin failures++; $display("FAIL match_p2_ready actual=%b expected=0", bus.p2_ready); end
    // Moves offered in DONE must be ignored.
    bus.p1_valid = 1'b1; bus.p1_move = S; bus.p2_valid = 1'b1; bus.p2_move = P;
    repeat (3) @(negedge clk);
    bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
    checks += 3;
    if (bus.out_cr !== 10'h2D5) begin failures++; $display("FAIL done_hold_out_cr actual=%h expected=2d5", bus.out_cr); end
    if (bus.round_idx !== 3'd5) begin failures++; $display("FAIL done_hold_idx actual=%0d expected=5", bus.round_idx); end
    if (bus.match_done !== 1'b1) begin failures++; $display("FAIL done_hold_done actual=%b expected=1", bus.match_done); end
    $display("test_full_match done");
  endtask

  task automatic test_invalid_move();
    pulse_start();
    bus.p1_valid = 1'b1; bus.p1_move = 2'b00;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); @(negedge clk);
      checks += 2;
      if (bus.p1_ready !== 1'b1) begin failures++; $display("FAIL invalid_p1_ready cyc=%0d actual=%b expected=1", c, bus.p1_ready); end
      if (bus.out_cr !== 10'h000) begin failures++; $display("FAIL invalid_out_cr cyc=%0d actual=%h expected=000", c, bus.out_cr); end
    end
    bus.p1_valid = 1'b0;
    checks += 1;
    if (bus.round_idx !== 3'd0) begin failures++; $display("FAIL invalid_idx actual=%0d expected=0", bus.round_idx); end
    $display("test_invalid_move done");
  endtask

  task automatic test_restart();
    play_round(R, S);
    play_round(R, S);
    checks += 2;
    if (bus.out_cr !== 10'h005) begin failures++; $display("FAIL restart_pre_out_cr actual=%h expected=005", bus.out_cr); end
    if (bus.round_idx !== 3'd2) begin failures++; $display("FAIL restart_pre_idx actual=%0d expected=2", bus.round_idx); end
    bus.p1_valid = 1'b1; bus.p1_move = P;
    @(posedge clk); @(negedge clk);
    bus.p1_valid = 1'b0;
    checks += 2;
    if (bus.p1_ready !== 1'b0) begin failures++; $display("FAIL latched_p1_ready actual=%b expected=0", bus.p1_ready); end
    if (bus.p2_ready !== 1'b1) begin failures++; $display("FAIL latched_p2_ready actual=%b expected=1", bus.p2_ready); end
    pulse_start();
    checks += 4;
    if (bus.out_cr !== 10'h000) begin failures++; $display("FAIL restart_out_cr actual=%h expected=000", bus.out_cr); end
    if (bus.round_idx !== 3'd0) begin failures++; $display("FAIL restart_idx actual=%0d expected=0", bus.round_idx); end
    if (bus.p1_ready !== 1'b1) begin failures++; $display("FAIL restart_p1_ready actual=%b expected=1", bus.p1_ready); end
    if (bus.p2_ready !== 1'b1) begin failures++; $display("FAIL restart_p2_ready actual=%b expected=1", bus.p2_ready); end
    $display("test_restart done");
  endtask

  task automatic test_same_edge_and_reset();
    bus.p1_valid = 1'b1; bus.p1_move = S; bus.p2_valid = 1'b1; bus.p2_move = R;
    @(posedge clk); @(negedge clk);
    bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
    checks += 3;
    if (bus.p1_ready !== 1'b0) begin failures++; $display("FAIL judge_p1_ready actual=%b expected=0", bus.p1_ready); end
    if (bus.p2_ready !== 1'b0) begin failures++; $display("FAIL judge_p2_ready actual=%b expected=0", bus.p2_ready); end
    if (bus.out_cr !== 10'h000) begin failures++; $display("FAIL judge_early_out_cr actual=%h expected=000", bus.out_cr); end
    @(posedge clk); @(negedge clk);
    checks += 2;
    if (bus.out_cr !== 10'h002) begin failures++; $display("FAIL same_edge_out_cr actual=%h expected=002", bus.out_cr); end
    if (bus.round_idx !== 3'd1) begin failures++; $display("FAIL same_edge_idx actual=%0d expected=1", bus.round_idx); end
    // Second round reaches JUDGE, then reset is asserted between edges.
    bus.p1_valid = 1'b1; bus.p1_move = P; bus.p2_valid = 1'b1; bus.p2_move = R;
    @(posedge clk); @(negedge clk);
    bus.p1_valid = 1'b0; bus.p2_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks += 5;
    if (bus.out_cr !== 10'h000) begin failures++; $display("FAIL async_rst_out_cr actual=%h expected=000", bus.out_cr); end
    if (bus.round_idx !== 3'd0) begin failures++; $display("FAIL async_rst_idx actual=%0d expected=0", bus.round_idx); end
    if (bus.p1_ready !== 1'b0) begin failures++; $display("FAIL async_rst_p1_ready actual=%b expected=0", bus.p1_ready); end
    if (bus.p2_ready !== 1'b0) begin failures++; $display("FAIL async_rst_p2_ready actual=%b expected=0", bus.p2_ready); end
    if (bus.match_done !== 1'b0) begin failures++; $display("FAIL async_rst_done actual=%b expected=0", bus.match_done); end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checks += 1;
    if (bus.out_cr !== 10'h000) begin failures++; $display("FAIL post_rst_out_cr actual=%h expected=000", bus.out_cr); end
    $display("test_same_edge_and_reset done");
  endtask

  task automatic test_timeout();
    pulse_start();
    bus.p1_valid = 1'b1; bus.p1_move = R;
    @(posedge clk); @(negedge clk);
    bus.p1_valid = 1'b0;
`ifdef ROUND_TIMEOUT_EN
    begin
      int waited;
      waited = 0;
      while (bus.round_idx !== 3'd1 && waited < 30) begin
        @(posedge clk); @(negedge clk);
        waited++;
      end
      checks += 2;
      if (waited >= 30) begin failures++; $display("FAIL timeout_wait actual=expired expected=round_idx 1 within 30 cycles"); end
      if (bus.out_cr !== 10'h001) begin failures++; $display("FAIL timeout_out_cr actual=%h expected=001", bus.out_cr); end
    end
`else
    repeat (300) @(negedge clk);
    checks += 4;
    if (bus.out_cr !== 10'h000) begin failures++; $display("FAIL no_timeout_out_cr actual=%h expected=000", bus.out_cr); end
    if (bus.round_idx !== 3'd0) begin failures++; $display("FAIL no_timeout_idx actual=%0d expected=0", bus.round_idx); end
    if (bus.p1_ready !== 1'b0) begin failures++; $display("FAIL no_timeout_p1_ready actual=%b expected=0", bus.p1_ready); end
    if (bus.p2_ready !== 1'b1) begin failures++; $display("FAIL no_timeout_p2_ready actual=%b expected=1", bus.p2_ready); end
    // Late opponent still completes the round: rock vs scissors.
    bus.p2_valid = 1'b1; bus.p2_move = S;
    @(posedge clk); @(negedge clk);
    bus.p2_valid = 1'b0;
    @(posedge clk); @(negedge clk);
    checks += 1;
    if (bus.out_cr !== 10'h001) begin failures++; $display("FAIL late_p2_out_cr actual=%h expected=001", bus.out_cr); end
`endif
    $display("test_timeout done");
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_full_match();
    test_invalid_move();
    test_restart();
    test_same_edge_and_reset();
    test_timeout();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
